// File: rtl/song_seq_ctrl_if.sv
// Command, ROM-note and playback-status bundle shared by the song sequencer and its user.
// The master drives commands and ROM notes; the slave (the sequencer) drives status and note index.
interface song_seq_ctrl_if;
    logic       btn_play;
    logic       btn_pause;
    logic       btn_stop;
    logic       btn_next;
    logic       btn_prev;
    logic       loop_en;
    logic       auto_next;
    logic [4:0] music0;
    logic [4:0] music1;
    logic [4:0] music2;
    logic [4:0] music3;
    logic [1:0] state;
    logic [5:0] note_idx;
    logic [1:0] song_sel;
    logic [4:0] music_out;
    logic       note_tick;
    logic       song_done;

    modport master (
        output btn_play, btn_pause, btn_stop, btn_next, btn_prev,
        output loop_en, auto_next,
        output music0, music1, music2, music3,
        input  state, note_idx, song_sel, music_out, note_tick, song_done
    );

    modport slave (
        input  btn_play, btn_pause, btn_stop, btn_next, btn_prev,
        input  loop_en, auto_next,
        input  music0, music1, music2, music3,
        output state, note_idx, song_sel, music_out, note_tick, song_done
    );
endinterface

// File: rtl/song_seq_ctrl.sv
// Song playback controller: play/pause/stop FSM, note-rate timebase, shared ROM note index
// and registered selection of the current song's note code.
module song_seq_ctrl #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned NOTE_HZ   = 4,
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned SONG_LEN  = 64
) (
    input  logic           clk,
    input  logic           reset,
    song_seq_ctrl_if.slave bus
);

    localparam int unsigned TICK_DIV = CLK_HZ / NOTE_HZ;
    localparam int unsigned DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DivMax    = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DivZero   = '0;
    localparam logic [DIV_W-1:0] DivOne    = DIV_W'(1);
    localparam logic [5:0]       IdxLast   = 6'(SONG_LEN - 1);
    localparam logic [1:0]       SongLast  = 2'(NUM_SONGS - 1);
    localparam logic [2:0]       NumSongs3 = 3'(NUM_SONGS);

    typedef enum logic [1:0] {
        StStop  = 2'b00,
        StPlay  = 2'b01,
        StPause = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       note_idx_q, note_idx_d;
    logic [1:0]       song_sel_q, song_sel_d;
    logic [4:0]       music_out_q, music_out_d;
    logic             note_tick_q, note_tick_d;
    logic             song_done_q, song_done_d;

    logic       any_cmd;
    logic [1:0] song_inc;
    logic [1:0] song_dec;
    logic [4:0] sel_music;

    assign any_cmd = bus.btn_stop | bus.btn_pause | bus.btn_play | bus.btn_next | bus.btn_prev;

    assign song_inc = (song_sel_q == SongLast) ? 2'd0 : song_sel_q + 2'd1;
    assign song_dec = (song_sel_q == 2'd0) ? SongLast : song_sel_q - 2'd1;

    // Out-of-range selection can only arise from a corrupted register; it plays silence.
    always_comb begin
        sel_music = 5'd0;
        if ({1'b0, song_sel_q} < NumSongs3) begin
            unique case (song_sel_q)
                2'd0:    sel_music = bus.music0;
                2'd1:    sel_music = bus.music1;
                2'd2:    sel_music = bus.music2;
                2'd3:    sel_music = bus.music3;
                default: sel_music = 5'd0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        note_idx_d  = note_idx_q;
        song_sel_d  = song_sel_q;
        note_tick_d = 1'b0;
        song_done_d = 1'b0;
        music_out_d = (state_q == StPlay) ? sel_music : 5'd0;

        // Timebase; any command present in the tick cycle suppresses the step.
        if (state_q == StPlay) begin
            if (div_q == DivMax) begin
                if (!any_cmd) begin
                    div_d       = DivZero;
                    note_tick_d = 1'b1;
                    if (note_idx_q == IdxLast) begin
                        song_done_d = 1'b1;
                        note_idx_d  = 6'd0;
                        if (bus.loop_en) begin
                            state_d = StPlay;
                        end else if (bus.auto_next) begin
                            song_sel_d = song_inc;
                        end else begin
                            state_d = StStop;
                        end
                    end else begin
                        note_idx_d = note_idx_q + 6'd1;
                    end
                end
            end else begin
                div_d = div_q + DivOne;
            end
        end

        // Only the highest-priority command is considered, even if it has no effect.
        if (bus.btn_stop) begin
            if (state_q != StStop) begin
                state_d    = StStop;
                note_idx_d = 6'd0;
                div_d      = DivZero;
            end
        end else if (bus.btn_pause) begin
            if (state_q == StPlay) begin
                state_d    = StPause;
                note_idx_d = note_idx_q;
                div_d      = div_q;
            end
        end else if (bus.btn_play) begin
            if (state_q == StStop) begin
                state_d    = StPlay;
                note_idx_d = 6'd0;
                div_d      = DivZero;
            end else if (state_q == StPause) begin
                state_d = StPlay;
            end
        end else if (bus.btn_next) begin
            song_sel_d = song_inc;
            note_idx_d = 6'd0;
            div_d      = DivZero;
        end else if (bus.btn_prev) begin
            song_sel_d = song_dec;
            note_idx_d = 6'd0;
            div_d      = DivZero;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StStop;
            div_q       <= DivZero;
            note_idx_q  <= 6'd0;
            song_sel_q  <= 2'd0;
            music_out_q <= 5'd0;
            note_tick_q <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            note_idx_q  <= note_idx_d;
            song_sel_q  <= song_sel_d;
            music_out_q <= music_out_d;
            note_tick_q <= note_tick_d;
            song_done_q <= song_done_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.note_idx  = note_idx_q;
    assign bus.song_sel  = song_sel_q;
    assign bus.music_out = music_out_q;
    assign bus.note_tick = note_tick_q;
    assign bus.song_done = song_done_q;

endmodule

// File: tb/tb_song_seq_ctrl.sv
// Directed bench for song_seq_ctrl with TICK_DIV=4, SONG_LEN=4, NUM_SONGS=3.
// Expectations are queued as commands are driven and checked once the DUT has responded.
module tb_song_seq_ctrl;

    localparam logic [4:0] C_STOP  = 5'b10000;
    localparam logic [4:0] C_PAUSE = 5'b01000;
    localparam logic [4:0] C_PLAY  = 5'b00100;
    localparam logic [4:0] C_NEXT  = 5'b00010;
    localparam logic [4:0] C_PREV  = 5'b00001;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [5:0] idx;
        logic [1:0] sel;
        logic [4:0] mus;
        logic       tick;
        logic       done;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    exp_t sb_q[$];

    song_seq_ctrl_if bus();

    song_seq_ctrl #(
        .CLK_HZ   (8),
        .NOTE_HZ  (2),
        .NUM_SONGS(3),
        .SONG_LEN (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_btns();
        bus.btn_stop  = 1'b0;
        bus.btn_pause = 1'b0;
        bus.btn_play  = 1'b0;
        bus.btn_next  = 1'b0;
        bus.btn_prev  = 1'b0;
    endtask

    task automatic cmd(input logic [4:0] b);
        bus.btn_stop  = b[4];
        bus.btn_pause = b[3];
        bus.btn_play  = b[2];
        bus.btn_next  = b[1];
        bus.btn_prev  = b[0];
        step(1);
        clear_btns();
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic [5:0] idx,
                        input logic [1:0] sel, input logic [4:0] mus, input logic tick,
                        input logic done);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.idx  = idx;
        e.sel  = sel;
        e.mus  = mus;
        e.tick = tick;
        e.done = done;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input string field, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, "state",     8'(bus.state),     8'(e.st));
            chk(e.tag, "note_idx",  8'(bus.note_idx),  8'(e.idx));
            chk(e.tag, "song_sel",  8'(bus.song_sel),  8'(e.sel));
            chk(e.tag, "music_out", 8'(bus.music_out), 8'(e.mus));
            chk(e.tag, "note_tick", 8'(bus.note_tick), 8'(e.tick));
            chk(e.tag, "song_done", 8'(bus.song_done), 8'(e.done));
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        reset         = 1'b0;
        clear_btns();
        bus.loop_en   = 1'b0;
        bus.auto_next = 1'b0;
        bus.music0    = 5'd5;
        bus.music1    = 5'd9;
        bus.music2    = 5'd17;
        bus.music3    = 5'd3;

        step(2);
        push("reset_state", 2'd0, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); compare();
        reset = 1'b1;
        push("idle_stop", 2'd0, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); step(3); compare();
        push("pause_in_stop", 2'd0, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PAUSE); compare();

        // Play from reset: ticks 4, 8, 12 cycles after the play pulse.
        push("play_entry", 2'd1, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PLAY); compare();
        push("music_latency", 2'd1, 6'd0, 2'd0, 5'd5, 1'b0, 1'b0); step(1); compare();
        for (int k = 1; k <= 3; k++) begin
            push("pre_tick", 2'd1, 6'(k - 1), 2'd0, 5'd5, 1'b0, 1'b0);
            step((k == 1) ? 2 : 3);
            compare();
            push("tick", 2'd1, 6'(k), 2'd0, 5'd5, 1'b1, 1'b0); step(1); compare();
        end
        push("end_stop", 2'd0, 6'd0, 2'd0, 5'd5, 1'b1, 1'b1); step(4); compare();
        push("after_end", 2'd0, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); step(1); compare();

        // Pause at div=2, note_idx=1, then resume.
        push("replay", 2'd1, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PLAY); compare();
        step(6);
        push("pause", 2'd2, 6'd1, 2'd0, 5'd5, 1'b0, 1'b0); cmd(C_PAUSE); compare();
        for (int i = 0; i < 10; i++) begin
            push("paused", 2'd2, 6'd1, 2'd0, 5'd0, 1'b0, 1'b0); step(1); compare();
        end
        push("resume", 2'd1, 6'd1, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PLAY); compare();
        push("resume_pre", 2'd1, 6'd1, 2'd0, 5'd5, 1'b0, 1'b0); step(1); compare();
        push("resume_tick", 2'd1, 6'd2, 2'd0, 5'd5, 1'b1, 1'b0); step(1); compare();

        bus.loop_en = 1'b1;
        push("loop_end", 2'd1, 6'd0, 2'd0, 5'd5, 1'b1, 1'b1); step(8); compare();
        bus.loop_en   = 1'b0;
        bus.auto_next = 1'b1;

        push("prev_play", 2'd1, 6'd0, 2'd2, 5'd5, 1'b0, 1'b0); cmd(C_PREV); compare();
        push("sel2_music", 2'd1, 6'd0, 2'd2, 5'd17, 1'b0, 1'b0); step(1); compare();
        push("auto_next_end", 2'd1, 6'd0, 2'd0, 5'd17, 1'b1, 1'b1); step(15); compare();
        push("auto_next_mus", 2'd1, 6'd0, 2'd0, 5'd5, 1'b0, 1'b0); step(1); compare();
        bus.auto_next = 1'b0;

        // Song select wraps while paused.
        push("pause2", 2'd2, 6'd0, 2'd0, 5'd5, 1'b0, 1'b0); cmd(C_PAUSE); compare();
        push("prev_wrap", 2'd2, 6'd0, 2'd2, 5'd0, 1'b0, 1'b0); cmd(C_PREV); compare();
        push("next_wrap", 2'd2, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_NEXT); compare();

        // Simultaneous events.
        push("resume2", 2'd1, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PLAY); compare();
        push("stop_over_play", 2'd0, 6'd0, 2'd0, 5'd5, 1'b0, 1'b0); cmd(C_STOP | C_PLAY);
        compare();
        push("play3", 2'd1, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PLAY); compare();
        step(15);
        push("pause_final", 2'd2, 6'd3, 2'd0, 5'd5, 1'b0, 1'b0); cmd(C_PAUSE); compare();
        push("pause_final_hold", 2'd2, 6'd3, 2'd0, 5'd0, 1'b0, 1'b0); step(2); compare();

        // Asynchronous reset between clock edges.
        push("stop_again", 2'd0, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_STOP); compare();
        push("play4", 2'd1, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PLAY); compare();
        push("pre_reset", 2'd1, 6'd1, 2'd0, 5'd5, 1'b1, 1'b0); step(4); compare();
        #2;
        reset = 1'b0;
        push("async_reset", 2'd0, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        #1;
        compare();
        step(1);
        reset = 1'b1;
        push("post_reset", 2'd0, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); step(1); compare();
        push("restart", 2'd1, 6'd0, 2'd0, 5'd0, 1'b0, 1'b0); cmd(C_PLAY); compare();
        push("restart_tick", 2'd1, 6'd1, 2'd0, 5'd5, 1'b1, 1'b0); step(4); compare();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/song_seq_ctrl.md
Name: song_seq_ctrl

Overview:
- Playback controller for the song memory blocks.
- Takes single-cycle user command pulses and runs the play/pause/stop state machine.
- Generates the note-rate timebase and drives the shared 6-bit note index into every song ROM.
- Selects one of up to four ROM note outputs and registers it as the note code for the tone generator; handles end-of-song looping, auto-advance or stopping.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- NOTE_HZ, 4, note-step rate in Hz. TICK_DIV = CLK_HZ/NOTE_HZ, integer, at least 2.
- NUM_SONGS, 4, number of songs attached, 1..4.
- SONG_LEN, 64, number of note slots per song, 2..64.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- btn_play, input, 1: play/resume command pulse.
- btn_pause, input, 1: pause command pulse.
- btn_stop, input, 1: stop command pulse.
- btn_next, input, 1: next-song command pulse.
- btn_prev, input, 1: previous-song command pulse.
- loop_en, input, 1: repeat the current song at its end.
- auto_next, input, 1: advance to the next song at its end (ignored when loop_en=1).
- music0, music1, music2, music3, input, 5 each: note codes from song ROMs 0..3. Codes 0..21; 0 = silence.
- state, output, 2: 2'b00 STOP, 2'b01 PLAY, 2'b10 PAUSE; 2'b11 is never driven.
- note_idx, output, 6: note index driven to all ROMs.
- song_sel, output, 2: current song number.
- music_out, output, 5: registered selected note code.
- note_tick, output, 1: one-cycle pulse on each note step.
- song_done, output, 1: one-cycle pulse when the last slot of a song completes.

Behaviour:
- Reset values: state=STOP, note_idx=0, song_sel=0, music_out=0, note_tick=0, song_done=0, internal divider div=0.
- Commands are one-cycle pulses, debounced upstream. Priority per cycle: stop > pause > play > next > prev. Only the highest-priority command present is acted on.
- STOP state:
  - play -> PLAY, note_idx=0, div=0.
  - pause and stop have no effect.
- PLAY state:
  - pause -> PAUSE; note_idx and div hold.
  - stop -> STOP; note_idx=0, div=0.
  - play has no effect.
- PAUSE state:
  - play -> PLAY, resuming from the held note_idx and div.
  - stop -> STOP; note_idx=0, div=0.
- next/prev, in any state:
  - song_sel = (song_sel ± 1) mod NUM_SONGS, wrapping 0 <-> NUM_SONGS-1.
  - note_idx=0, div=0; state is unchanged.
- Timebase, PLAY only:
  - div counts 0..TICK_DIV-1.
  - In the cycle div==TICK_DIV-1, note_tick=1 the next cycle, div -> 0 and note_idx advances.
  - With no command, the first note_tick occurs TICK_DIV cycles after entering PLAY.
  - note_tick=0 in STOP and PAUSE.
- End of song: a tick with note_idx==SONG_LEN-1 raises song_done for one cycle (same cycle as note_tick), then:
  - loop_en=1: note_idx=0, stay in PLAY.
  - else if auto_next=1: song_sel advances with wrap, note_idx=0, stay in PLAY.
  - else: STOP, note_idx=0.
- Simultaneous events:
  - Any command in a tick cycle overrides the tick: no note advance, no note_tick, no song_done; the command takes effect as above.
  - pause on the final-slot tick therefore holds note_idx at SONG_LEN-1.
- Output mux and latency:
  - music_out <= music[song_sel] when state==PLAY, else 0. This is a one-cycle registered latency.
  - music_out is 0 on the cycle after leaving PLAY.
  - The ROMs are treated as combinational on note_idx.
  - If song_sel >= NUM_SONGS (unreachable), music_out=0.
- Arithmetic:
  - note_idx and song_sel never exceed SONG_LEN-1 and NUM_SONGS-1.
  - div width is clog2(TICK_DIV); there is no overflow path.
- Asynchronous reset mid-operation forces all reset values immediately. The first edge after release behaves as in STOP.

Test Plan:
- Common bench settings: CLK_HZ=8, NOTE_HZ=2 (TICK_DIV=4), SONG_LEN=4, NUM_SONGS=3.
- Play from reset: pulse btn_play, music0=5. Required:
  - state=01.
  - note_tick on cycles 4, 8, 12 after the pulse; note_idx steps 1, 2, 3.
  - music_out=5 one cycle after PLAY entry.
- Pause/resume at div=2, note_idx=1: pause for 10 cycles, then play. Required:
  - note_idx stays 1 and music_out=0 during pause.
  - After play, the next tick comes 2 cycles later and note_idx=2.
- End of song, loop_en=0, auto_next=0: at the tick on note_idx=3, song_done=1 and note_tick=1. Next cycle: state=00, note_idx=0.
  - Repeat with loop_en=1: note_idx=0, state stays 01.
  - Repeat with auto_next=1, song_sel=2: song_sel wraps to 0, state stays 01.
- Song select wrap: btn_prev from song_sel=0 gives 2; btn_next from 2 gives 0; note_idx=0 each time; state is preserved in PAUSE.
- Simultaneous events:
  - btn_stop and btn_play together in PLAY -> STOP.
  - btn_pause in the final-slot tick cycle -> PAUSE, note_idx=3, song_done=0.
- Async reset: assert reset low mid-PLAY between clock edges. Required: all outputs go to reset values before the next edge; btn_play after release restarts at note_idx=0.
